moore_seq_det: RTL and testbench

Parametrised Moore-type serial sequence detector that succeeds the fixed 1011 detector. It watches a one-bit serial stream and asserts a registered match flag for one state-hold period after a runtime-programmable PAT_W-bit pattern has been received. Overlapping or non-overlapping detection is selectable, and an optional saturating counter records detections. It sits directly on serial front-end bit streams, one instance per monitored stream.

---
 rtl/moore_det_pkg.sv | 12 +
 rtl/moore_seq_next.sv | 64 ++++++
 rtl/moore_seq_det.sv | 95 +++++++++
 tb/tb_moore_seq_det.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/moore_det_pkg.sv
// moore_det_pkg: shared definitions for the moore_seq_det serial pattern detector.
//   st_w(pat_w) : width of the matched-prefix state register, $clog2(pat_w+1)
//   DEF_PAT     : default pattern loaded at reset (1011, first bit is the MSB)
package moore_det_pkg;

  localparam logic [3:0] DEF_PAT = 4'b1011;

  function automatic int unsigned st_w(input int unsigned pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/moore_seq_next.sv
// moore_seq_next: combinational next-state function for the sequence detector.
// Returns the longest pattern prefix that is a suffix of (matched prefix ++ b).
// Ports:
//   pattern    in  PAT_W  detected pattern, bit PAT_W-1 is the first expected bit
//   state      in  SW     current matched-prefix length (PAT_W = MATCH)
//   b          in  1      incoming serial bit
//   overlap    in  1      1 = keep trailing prefix after MATCH, 0 = restart from S_0
//   next_state out SW     next matched-prefix length
module moore_seq_next
  import moore_det_pkg::*;
#(
  parameter int unsigned PAT_W = 4
) (
  input  logic [PAT_W-1:0]           pattern,
  input  logic [st_w(PAT_W)-1:0]     state,
  input  logic                       b,
  input  logic                       overlap,
  output logic [st_w(PAT_W)-1:0]     next_state
);

  localparam int unsigned SW = st_w(PAT_W);
  localparam logic [SW-1:0] MATCH_ST = SW'(PAT_W);

  always_comb begin
    logic [PAT_W-1:0] shv;
    int unsigned      k;
    int unsigned      j;
    logic             ok;
    logic             sbit;

    next_state = '0;
    shv        = '0;
    j          = 0;
    ok         = 1'b0;
    sbit       = 1'b0;

    // Non-overlapping mode forgets the completed match entirely.
    if (state == MATCH_ST) k = overlap ? PAT_W : 0;
    else                   k = 32'(state);

    // The seen sequence is pattern[first k bits] followed by b (length k+1).
    // Try every candidate length; the last one that fits is the longest.
    for (int unsigned l = 1; l <= PAT_W; l++) begin
      if (l <= k + 1) begin
        ok = 1'b1;
        for (int unsigned i = 0; i < PAT_W; i++) begin
          if (i < l) begin
            j = k + 1 - l + i;
            if (j == k) begin
              sbit = b;
            end else begin
              shv  = pattern >> (PAT_W - 1 - j);
              sbit = shv[0];
            end
            shv = pattern >> (PAT_W - 1 - i);
            if (sbit != shv[0]) ok = 1'b0;
          end
        end
        if (ok) next_state = SW'(l);
      end
    end
  end

endmodule

// File: rtl/moore_seq_det.sv
// moore_seq_det: Moore serial sequence detector with a programmable PAT_W-bit
// pattern, selectable overlapping detection and an optional saturating counter.
// Build option: define MOORE_DET_COUNT_EN to compile in the detection counter;
// otherwise count is tied to 0 and no counter flops exist.
// Ports:
//   clk      in  1      rising-edge clock
//   reset    in  1      asynchronous active-low reset
//   en       in  1      x valid this cycle; state holds when low
//   x        in  1      serial data bit
//   overlap  in  1      1 = overlapping, 0 = non-overlapping detection
//   load     in  1      load pat_in and return to S_0 (x on this edge discarded)
//   pat_in   in  PAT_W  new pattern, MSB is first bit expected
//   z        out 1      match flag, high only in MATCH state
//   state    out SW     matched-prefix length (debug)
//   count    out CNT_W  saturating detection count
module moore_seq_det
  import moore_det_pkg::*;
#(
  parameter int unsigned      PAT_W   = 4,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(DEF_PAT),
  parameter int unsigned      CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   x,
  input  logic                   overlap,
  input  logic                   load,
  input  logic [PAT_W-1:0]       pat_in,
  output logic                   z,
  output logic [st_w(PAT_W)-1:0] state,
  output logic [CNT_W-1:0]       count
);

  localparam int unsigned   SW       = st_w(PAT_W);
  localparam logic [SW-1:0] MATCH_ST = SW'(PAT_W);

  logic [SW-1:0]    state_q, state_d, nxt_state;
  logic [PAT_W-1:0] pat_q, pat_d;

  moore_seq_next #(
    .PAT_W(PAT_W)
  ) u_next (
    .pattern   (pat_q),
    .state     (state_q),
    .b         (x),
    .overlap   (overlap),
    .next_state(nxt_state)
  );

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    if (load) begin
      pat_d   = pat_in;
      state_d = '0;
    end else if (en) begin
      state_d = nxt_state;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= '0;
      pat_q   <= RST_PAT;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
    end
  end

  assign z     = (state_q == MATCH_ST);
  assign state = state_q;

`ifdef MOORE_DET_COUNT_EN
  logic [CNT_W-1:0] count_q, count_d;

  // Counts every accepted edge that lands in MATCH, including MATCH->MATCH.
  always_comb begin
    count_d = count_q;
    if (!load && en && (nxt_state == MATCH_ST) && (count_q != '1))
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;
`else
  assign count = '0;
`endif

endmodule

// File: tb/tb_moore_seq_det.sv
// Self-checking bench for moore_seq_det: table of stimulus/expected-state
// records, a scoreboard queue, and a hand-written asynchronous reset sequence.
// A second instance with CNT_W=2 exercises counter saturation.
module tb_moore_seq_det;
  import moore_det_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0, x = 1'b0, overlap = 1'b0, load = 1'b0;
  logic [3:0] pat_in = '0;
  logic       z, z_s;
  logic [2:0] state, state_s;
  logic [7:0] count;
  logic [1:0] count_s;

  always #5 clk = ~clk;

  moore_seq_det #(.PAT_W(4), .RST_PAT(4'b1011), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .en(en), .x(x), .overlap(overlap), .load(load),
    .pat_in(pat_in), .z(z), .state(state), .count(count)
  );

  moore_seq_det #(.PAT_W(4), .RST_PAT(4'b1011), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .en(en), .x(x), .overlap(overlap), .load(load),
    .pat_in(pat_in), .z(z_s), .state(state_s), .count(count_s)
  );

  typedef struct {
    logic       ld, e, b, ov;
    logic [3:0] pat;
    logic [2:0] st;
  } vec_t;

  typedef struct {
    logic [2:0] st;
    int         cnt;
    int         sat;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned mcount = 0;
  int          n1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic void add(input logic ld, e, b, ov, input logic [3:0] pat,
                              input logic [2:0] st);
    vec_t v;
    v.ld = ld; v.e = e; v.b = b; v.ov = ov; v.pat = pat; v.st = st;
    vecs.push_back(v);
  endfunction

  function automatic int exp_cnt(input int unsigned m, input int unsigned maxv);
`ifdef MOORE_DET_COUNT_EN
    return (m > maxv) ? int'(maxv) : int'(m);
`else
    return 0;
`endif
  endfunction

  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, " scoreboard_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    chk({tag, " state"}, int'(state), int'(e.st));
    chk({tag, " z"}, int'(z), int'(e.st == 3'd4));
    chk({tag, " count"}, int'(count), e.cnt);
    chk({tag, " sat_count"}, int'(count_s), e.sat);
  endtask

  task automatic drive(input vec_t v, input string tag);
    exp_t e;
    @(negedge clk);
    load = v.ld; en = v.e; x = v.b; overlap = v.ov; pat_in = v.pat;
    if (v.e && !v.ld && v.st == 3'd4) mcount++;
    e.st  = v.st;
    e.cnt = exp_cnt(mcount, 255);
    e.sat = exp_cnt(mcount, 3);
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  initial begin
    // Part 1: pattern 1011 from reset
    // overlapping 1,0,1,1,0,1,1
    add(0,1,1,1,4'h0,1); add(0,1,0,1,4'h0,2); add(0,1,1,1,4'h0,3); add(0,1,1,1,4'h0,4);
    add(0,1,0,1,4'h0,2); add(0,1,1,1,4'h0,3); add(0,1,1,1,4'h0,4);
    // back to S_0, then same stream non-overlapping
    add(1,1,1,0,4'b1011,0);
    add(0,1,1,0,4'h5,1); add(0,1,0,0,4'h5,2); add(0,1,1,0,4'h5,3); add(0,1,1,0,4'h5,4);
    add(0,1,0,0,4'h5,0); add(0,1,1,0,4'h5,1); add(0,1,1,0,4'h5,1);
    // pattern 1111, six 1s overlapping
    add(1,0,0,1,4'b1111,0);
    add(0,1,1,1,4'h0,1); add(0,1,1,1,4'h0,2); add(0,1,1,1,4'h0,3);
    add(0,1,1,1,4'h0,4); add(0,1,1,1,4'h0,4); add(0,1,1,1,4'h0,4);
    // pattern 1111, six 1s non-overlapping
    add(1,0,1,0,4'b1111,0);
    add(0,1,1,0,4'h0,1); add(0,1,1,0,4'h0,2); add(0,1,1,0,4'h0,3);
    add(0,1,1,0,4'h0,4); add(0,1,1,0,4'h0,1); add(0,1,1,0,4'h0,2);
    // pattern 1011: stall mid-prefix, then stall in MATCH, then overlap switched on
    add(1,0,0,0,4'b1011,0);
    add(0,1,1,0,4'h0,1); add(0,1,0,0,4'h0,2); add(0,1,1,0,4'h0,3);
    add(0,0,1,0,4'h0,3); add(0,0,0,0,4'h0,3); add(0,0,1,0,4'h0,3);
    add(0,1,1,0,4'h0,4);
    add(0,0,0,0,4'h0,4); add(0,0,1,0,4'h0,4);
    add(0,1,0,1,4'h0,2);
    // prefix before the asynchronous reset
    add(1,0,0,1,4'b1011,0);
    add(0,1,1,1,4'h0,1); add(0,1,0,1,4'h0,2); add(0,1,1,1,4'h0,3);
    n1 = vecs.size();
    // Part 2 (after reset): 0,1,1 gives no match
    add(0,1,0,1,4'h0,0); add(0,1,1,1,4'h0,1); add(0,1,1,1,4'h0,1);
    // load together with en on the 4th bit of 1011
    add(0,1,1,1,4'h0,1); add(0,1,0,1,4'h0,2); add(0,1,1,1,4'h0,3);
    add(1,1,1,1,4'b1011,0);
    // five overlapping matches: saturates the CNT_W=2 instance
    add(0,1,1,1,4'h0,1); add(0,1,0,1,4'h0,2); add(0,1,1,1,4'h0,3); add(0,1,1,1,4'h0,4);
    for (int unsigned r = 0; r < 4; r++) begin
      add(0,1,0,1,4'h0,2); add(0,1,1,1,4'h0,3); add(0,1,1,1,4'h0,4);
    end

    // reset state
    #3;
    chk("reset state", int'(state), 0);
    chk("reset z", int'(z), 0);
    chk("reset count", int'(count), 0);
    #5 reset = 1'b1;

    for (int i = 0; i < n1; i++) drive(vecs[i], $sformatf("v%0d", i));

    // asynchronous reset mid-sequence, away from any clock edge
    #1 reset = 1'b0;
    #1;
    mcount = 0;
    chk("async_rst state", int'(state), 0);
    chk("async_rst z", int'(z), 0);
    chk("async_rst count", int'(count), 0);
    chk("async_rst sat_count", int'(count_s), 0);
    #1 reset = 1'b1;

    for (int i = n1; i < vecs.size(); i++) drive(vecs[i], $sformatf("v%0d", i));

    chk("scoreboard drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
